// File: rtl/mrc_std_fmt_pkg.sv
// mrc_std_fmt_pkg: shared STD lane framing encodings and formatter FSM states.
package mrc_std_fmt_pkg;
  localparam logic [1:0] STD_CNTL_MOM     = 2'b00;
  localparam logic [1:0] STD_CNTL_SOM     = 2'b01;
  localparam logic [1:0] STD_CNTL_EOM     = 2'b10;
  localparam logic [1:0] STD_CNTL_SOM_EOM = 2'b11;
  typedef enum logic {ST_IDLE, ST_STREAM} fmt_state_e;
endpackage

// File: rtl/mrc_std_fmt_fifo.sv
// mrc_std_fmt_fifo: synchronous word FIFO that absorbs the MRC/STD rate mismatch.
module mrc_std_fmt_fifo #(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_poweron,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push, do_pop;
  assign full_o  = count_q == CW'(FIFO_DEPTH);
  assign empty_o = count_q == '0;
  assign count_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem_q[wr_ptr_q] <= data_i;
endmodule

// File: rtl/mrc_to_std_lane_formatter.sv
// mrc_to_std_lane_formatter: frames buffered MRC read words into SOM/MOM/EOM messages on one STD lane.
// Optional macro MRC_STD_PERF_CNT_EN adds saturating handshake and stall counters.
module mrc_to_std_lane_formatter
  import mrc_std_fmt_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int LEN_W      = 16,
  parameter int TAG_W      = 8
) (
  input  logic              clk,
  input  logic              reset_poweron,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [LEN_W-1:0]  desc_num_words,
  input  logic [TAG_W-1:0]  desc_tag,
  input  logic              mrc_valid,
  output logic              mrc_ready,
  input  logic [DATA_W-1:0] mrc_data,
  output logic              std_valid,
  input  logic              std_ready,
  output logic [DATA_W-1:0] std_data,
  output logic [1:0]        std_cntl,
  output logic [TAG_W-1:0]  std_tag,
  output logic              busy,
  output logic              err_zero_len
`ifdef MRC_STD_PERF_CNT_EN
  ,
  output logic [31:0]       perf_words,
  output logic [31:0]       perf_stall_cycles
`endif
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  fmt_state_e        state_q, state_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic              first_q, first_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [1:0]        cntl_q, cntl_d;
  logic [TAG_W-1:0]  stag_q, stag_d;
  logic              fifo_full, fifo_empty, pop, last, desc_go;
  logic [DATA_W-1:0] fifo_data;
  logic [CW-1:0]     fifo_count;
  mrc_std_fmt_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .push_i        (mrc_valid),
    .data_i        (mrc_data),
    .pop_i         (pop),
    .data_o        (fifo_data),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .count_o       (fifo_count)
  );
  assign desc_ready = state_q == ST_IDLE;
  assign mrc_ready  = !fifo_full;
  assign desc_go    = desc_ready && desc_valid;
  assign last       = rem_q == LEN_W'(1);
  // the output register refills in the same cycle it is drained, giving 1 word/cycle
  assign pop        = state_q == ST_STREAM && !fifo_empty && (!vld_q || std_ready);
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    first_d = first_q;
    tag_d   = tag_q;
    err_d   = desc_go && desc_num_words == '0;
    vld_d   = vld_q && !std_ready;
    data_d  = data_q;
    cntl_d  = cntl_q;
    stag_d  = stag_q;
    if (desc_go && desc_num_words != '0) begin
      state_d = ST_STREAM;
      rem_d   = desc_num_words;
      first_d = 1'b1;
      tag_d   = desc_tag;
    end
    if (pop) begin
      vld_d   = 1'b1;
      data_d  = fifo_data;
      cntl_d  = last ? (first_q ? STD_CNTL_SOM_EOM : STD_CNTL_EOM)
                     : (first_q ? STD_CNTL_SOM : STD_CNTL_MOM);
      stag_d  = tag_q;
      first_d = 1'b0;
      rem_d   = rem_q - 1'b1;
      state_d = last ? ST_IDLE : state_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
      first_q <= 1'b0;
      tag_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      data_q  <= '0;
      cntl_q  <= '0;
      stag_q  <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      first_q <= first_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      data_q  <= data_d;
      cntl_q  <= cntl_d;
      stag_q  <= stag_d;
    end
  end
  always_ff @(posedge clk)
    if (reset_poweron) assert (fifo_empty == (fifo_count == '0));
  assign std_valid    = vld_q;
  assign std_data     = data_q;
  assign std_cntl     = cntl_q;
  assign std_tag      = stag_q;
  assign busy         = state_q == ST_STREAM || vld_q;
  assign err_zero_len = err_q;
`ifdef MRC_STD_PERF_CNT_EN
  logic [31:0] perf_words_q, perf_stall_q;
  always_ff @(posedge clk) begin
    if (!reset_poweron) begin
      perf_words_q <= '0;
      perf_stall_q <= '0;
    end else begin
      if (vld_q && std_ready && !(&perf_words_q)) perf_words_q <= perf_words_q + 32'd1;
      if (vld_q && !std_ready && !(&perf_stall_q)) perf_stall_q <= perf_stall_q + 32'd1;
    end
  end
  assign perf_words        = perf_words_q;
  assign perf_stall_cycles = perf_stall_q;
`endif
endmodule

// File: tb/tb_mrc_to_std_lane_formatter.sv
// tb_mrc_to_std_lane_formatter: directed table vectors plus multi-cycle corner sequences and a random scoreboard run.
module tb_mrc_to_std_lane_formatter;
  logic        clk = 1'b0, reset_poweron = 1'b0;
  logic        desc_valid = 1'b0, mrc_valid = 1'b0, std_ready = 1'b0;
  logic [15:0] desc_num_words = '0;
  logic [7:0]  desc_tag = '0;
  logic [31:0] mrc_data = '0;
  logic        desc_ready, mrc_ready, std_valid, busy, err_zero_len;
  logic [31:0] std_data;
  logic [1:0]  std_cntl;
  logic [7:0]  std_tag;
`ifdef MRC_STD_PERF_CNT_EN
  logic [31:0] perf_words, perf_stall_cycles;
`endif
  mrc_to_std_lane_formatter dut (
    .clk(clk), .reset_poweron(reset_poweron),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_num_words(desc_num_words), .desc_tag(desc_tag),
    .mrc_valid(mrc_valid), .mrc_ready(mrc_ready), .mrc_data(mrc_data),
    .std_valid(std_valid), .std_ready(std_ready), .std_data(std_data),
    .std_cntl(std_cntl), .std_tag(std_tag),
    .busy(busy), .err_zero_len(err_zero_len)
`ifdef MRC_STD_PERF_CNT_EN
    , .perf_words(perf_words), .perf_stall_cycles(perf_stall_cycles)
`endif
  );
  typedef struct {logic [31:0] d; logic [1:0] c; logic [7:0] t; int cy;} beat_t;
  typedef struct {int len; logic [7:0] tag; logic [31:0] base; logic [1:0] c_first; logic [1:0] c_last;} vec_t;
  int    checks = 0, errors = 0, cyc = 0, hs_cnt = 0, stall_cnt = 0;
  bit    hung = 1'b0;
  beat_t got_q[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (std_valid && std_ready) begin
      got_q.push_back('{std_data, std_cntl, std_tag, cyc});
      hs_cnt++;
    end
    if (std_valid && !std_ready) stall_cnt++;
  end
  initial begin
    #1500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_desc(input int n, input logic [7:0] t);
    if (hung) return;
    desc_valid = 1'b1;
    desc_num_words = 16'(n);
    desc_tag = t;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (desc_ready) break;
      if (i > 3000) begin
        chk("desc_timeout", 0, 1);
        hung = 1'b1;
        desc_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    desc_valid = 1'b0;
  endtask
  task automatic push_word(input logic [31:0] w);
    if (hung) return;
    mrc_valid = 1'b1;
    mrc_data = w;
    for (int i = 0; ; i++) begin
      @(negedge clk);
      if (mrc_ready) break;
      if (i > 3000) begin
        chk("mrc_timeout", 0, 1);
        hung = 1'b1;
        mrc_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    mrc_valid = 1'b0;
  endtask
  task automatic wait_beats(input int n, input int lim);
    for (int i = 0; got_q.size() < n; i++) begin
      if (i > lim || hung) begin
        chk("beat_timeout", 64'(got_q.size()), 64'(n));
        hung = 1'b1;
        return;
      end
      tick();
    end
  endtask
  task automatic check_msg(input int b, input vec_t v);
    logic [1:0] c;
    for (int i = 0; i < v.len; i++) begin
      if (b + i >= got_q.size()) begin
        chk($sformatf("msg_%0h_missing", v.tag), 64'(got_q.size()), 64'(b + v.len));
        return;
      end
      c = (i == 0) ? v.c_first : (i == v.len - 1) ? v.c_last : 2'b00;
      chk($sformatf("msg_%0h_beat%0d", v.tag, i),
          {got_q[b+i].d, got_q[b+i].c, got_q[b+i].t}, {v.base + 32'(i), c, v.tag});
    end
  endtask
  initial begin
    vec_t  vecs[7];
    vec_t  v;
    int    b, hs_base, stall_base, total;
    bit    rdone;
    int    lens[1000];
    logic [7:0]  tags[1000];
    logic [31:0] words_q[$];
    beat_t exp_q[$];
    vecs[0] = '{4,  8'h5A, 32'h000000A0, 2'b01, 2'b10};
    vecs[1] = '{1,  8'h33, 32'h00000010, 2'b11, 2'b11};
    vecs[2] = '{2,  8'h7E, 32'h00000020, 2'b01, 2'b10};
    vecs[3] = '{3,  8'h01, 32'h00000030, 2'b01, 2'b10};
    vecs[4] = '{8,  8'hC8, 32'h00000040, 2'b01, 2'b10};
    vecs[5] = '{9,  8'h99, 32'h00000050, 2'b01, 2'b10};
    vecs[6] = '{20, 8'h14, 32'h00000100, 2'b01, 2'b10};
    hs_base = 0;
    stall_base = 0;
    repeat (3) tick();
    chk("rst_std_valid", std_valid, 0);
    chk("rst_std_data", std_data, 0);
    chk("rst_std_cntl", std_cntl, 0);
    chk("rst_std_tag", std_tag, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err_zero_len, 0);
    chk("rst_desc_ready", desc_ready, 1);
    chk("rst_mrc_ready", mrc_ready, 1);
    reset_poweron = 1'b1;
    std_ready = 1'b1;
    tick();
    // first message: two-edge latency from the first MRC write
    b = got_q.size();
    send_desc(vecs[0].len, vecs[0].tag);
    mrc_valid = 1'b1;
    mrc_data = 32'hA0;
    tick();
    chk("lat_edge_k_valid", std_valid, 0);
    mrc_data = 32'hA1;
    tick();
    chk("lat_edge_k1", {std_valid, std_data, std_cntl, std_tag}, {1'b1, 32'hA0, 2'b01, 8'h5A});
    mrc_data = 32'hA2;
    tick();
    mrc_data = 32'hA3;
    tick();
    mrc_valid = 1'b0;
    wait_beats(b + 4, 100);
    check_msg(b, vecs[0]);
    for (int k = 1; k < 7; k++) begin
      b = got_q.size();
      send_desc(vecs[k].len, vecs[k].tag);
      for (int i = 0; i < vecs[k].len; i++) push_word(vecs[k].base + 32'(i));
      wait_beats(b + vecs[k].len, 200);
      check_msg(b, vecs[k]);
    end
    repeat (3) tick();
    chk("idle_after_table", {std_valid, busy}, 2'b00);
    // zero-length descriptor
    b = got_q.size();
    send_desc(0, 8'hEE);
    chk("zlen_pulse", err_zero_len, 1);
    chk("zlen_no_valid", std_valid, 0);
    tick();
    chk("zlen_pulse_end", err_zero_len, 0);
    chk("zlen_desc_ready", desc_ready, 1);
    chk("zlen_busy", busy, 0);
    repeat (3) tick();
    chk("zlen_no_beats", 64'(got_q.size()), 64'(b));
    // backpressure: fill FIFO behind a held output word
    std_ready = 1'b0;
    b = got_q.size();
    send_desc(6, 8'h66);
    for (int i = 0; i < 9; i++) push_word(32'hB0 + 32'(i));
    tick();
    chk("bp_mrc_ready", mrc_ready, 0);
    chk("bp_hold0", {std_valid, std_data, std_cntl, std_tag}, {1'b1, 32'hB0, 2'b01, 8'h66});
    repeat (10) tick();
    chk("bp_hold10", {std_valid, std_data, std_cntl, std_tag}, {1'b1, 32'hB0, 2'b01, 8'h66});
    chk("bp_mrc_ready_late", mrc_ready, 0);
    chk("bp_busy", busy, 1);
    std_ready = 1'b1;
    wait_beats(b + 6, 100);
    v = '{6, 8'h66, 32'hB0, 2'b01, 2'b10};
    check_msg(b, v);
    send_desc(3, 8'h77);
    wait_beats(b + 9, 100);
    v = '{3, 8'h77, 32'hB6, 2'b01, 2'b10};
    check_msg(b + 6, v);
    // back-to-back with prefetched data
    b = got_q.size();
    for (int i = 0; i < 5; i++) push_word(32'hD0 + 32'(i));
    send_desc(3, 8'h01);
    send_desc(2, 8'h02);
    wait_beats(b + 5, 100);
    v = '{3, 8'h01, 32'hD0, 2'b01, 2'b10};
    check_msg(b, v);
    v = '{2, 8'h02, 32'hD3, 2'b01, 2'b10};
    check_msg(b + 3, v);
    if (got_q.size() >= b + 5)
      chk("b2b_gap_le2", 64'(got_q[b+3].cy - got_q[b+2].cy <= 2), 1);
    // reset after the second beat of a five-word message
    std_ready = 1'b0;
    b = got_q.size();
    send_desc(5, 8'hC3);
    for (int i = 0; i < 5; i++) push_word(32'hC0 + 32'(i));
    std_ready = 1'b1;
    for (int i = 0; got_q.size() < b + 2 && i < 100; i++) tick();
    std_ready = 1'b0;
    reset_poweron = 1'b0;
    tick();
    hs_base = hs_cnt;
    stall_base = stall_cnt;
    chk("mid_rst_beats", 64'(got_q.size()), 64'(b + 2));
    if (got_q.size() >= b + 2) begin
      chk("mid_rst_beat0", {got_q[b].d, got_q[b].c}, {32'hC0, 2'b01});
      chk("mid_rst_beat1", {got_q[b+1].d, got_q[b+1].c}, {32'hC1, 2'b00});
    end
    chk("mid_rst_outs", {std_valid, std_data, std_cntl, std_tag, busy, err_zero_len}, '0);
    chk("mid_rst_readies", {desc_ready, mrc_ready}, 2'b11);
    tick();
    reset_poweron = 1'b1;
    std_ready = 1'b1;
    b = got_q.size();
    send_desc(2, 8'h3C);
    push_word(32'hE0);
    push_word(32'hE1);
    wait_beats(b + 2, 100);
    repeat (5) tick();
    chk("post_rst_beats", 64'(got_q.size()), 64'(b + 2));
    v = '{2, 8'h3C, 32'hE0, 2'b01, 2'b10};
    check_msg(b, v);
    // random traffic against a scoreboard
    total = 0;
    for (int m = 0; m < 1000; m++) begin
      lens[m] = $urandom_range(1, 20);
      tags[m] = 8'($urandom);
      for (int i = 0; i < lens[m]; i++) begin
        words_q.push_back($urandom);
        exp_q.push_back('{words_q[total], {i == lens[m] - 1, i == 0}, tags[m], 0});
        total++;
      end
    end
    b = got_q.size();
    rdone = 1'b0;
    fork
      begin
        for (int m = 0; m < 1000; m++) begin
          while ($urandom_range(0, 3) == 0) tick();
          send_desc(lens[m], tags[m]);
        end
      end
      begin
        for (int w = 0; w < total; w++) begin
          while ($urandom_range(0, 3) == 0) tick();
          push_word(words_q[w]);
        end
      end
      begin
        while (!rdone) begin
          tick();
          std_ready = 1'($urandom_range(0, 1));
        end
        std_ready = 1'b1;
      end
      begin
        wait_beats(b + total, 80000);
        rdone = 1'b1;
      end
    join
    repeat (5) tick();
    chk("rand_beat_count", 64'(got_q.size()), 64'(b + total));
    for (int i = 0; i < total && b + i < got_q.size(); i++)
      chk($sformatf("rand_beat%0d", i), {got_q[b+i].d, got_q[b+i].c, got_q[b+i].t},
          {exp_q[i].d, exp_q[i].c, exp_q[i].t});
`ifdef MRC_STD_PERF_CNT_EN
    chk("perf_words", perf_words, 64'(hs_cnt - hs_base));
    chk("perf_stall_cycles", perf_stall_cycles, 64'(stall_cnt - stall_base));
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
